regfile_wb_scheduler: RTL and testbench

Schedules the single write port of the 32x32 register file between two writeback sources. Source 0 is the core's single-cycle datapath. Source 1 is a long-latency unit (load/multiply).
A per-register busy scoreboard lets decode stall on operands still owned by source 1. The block sits between the writeback sources and the register file's WE3/A3/WD3 port, and feeds a stall signal back to decode.

---
 rtl/regfile_wb_scheduler_pkg.sv | 24 ++
 rtl/regfile_scoreboard.sv | 67 ++++++
 rtl/regfile_wb_scheduler.sv | 173 +++++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_scheduler_pkg
//  Description : Shared constants and types for the register-file writeback
//                scheduler: register address/data widths, the x0 index and
//                the writeback-source tag carried by the output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_scheduler_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  // Architectural register x0 is hardwired to zero.
  localparam logic [REG_AW-1:0] X0_IDX = '0;

  // Identifies which source produced the write held in the output stage.
  typedef enum logic {
    SRC_CORE = 1'b0,
    SRC_LONG = 1'b1
  } wb_src_e;

endpackage : regfile_wb_scheduler_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register busy tracking for registers owned by the
//                long-latency unit. Provides issue back-pressure and the
//                decode operand hazard.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                i_iss_valid/rd    - issue request to long-latency unit
//                o_iss_ready       - destination not busy (or x0)
//                i_clr_valid/addr  - source-1 write committing this cycle
//                i_rs1, i_rs2      - decode source registers
//                o_hazard          - either source register busy
//                o_busy            - busy vector (bit 0 constant 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = REG_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_iss_valid,
  input  logic [AW-1:0]    i_iss_rd,
  output logic             o_iss_ready,
  input  logic             i_clr_valid,
  input  logic [AW-1:0]    i_clr_addr,
  input  logic [AW-1:0]    i_rs1,
  input  logic [AW-1:0]    i_rs2,
  output logic             o_hazard,
  output logic [NREGS-1:0] o_busy
);

  logic w_iss_x0;
  logic w_set;

  assign w_iss_x0    = (i_iss_rd == AW'(X0_IDX));
  assign o_iss_ready = w_iss_x0 | ~o_busy[i_iss_rd];
  assign w_set       = i_iss_valid & o_iss_ready & ~w_iss_x0;

  // x0 can never be owned by the long-latency unit.
  assign o_busy[0] = 1'b0;

  generate
    for (genvar i = 1; i < NREGS; i++) begin : g_busy
      logic r_bit;

      // Set has priority over clear on the same edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_bit <= 1'b0;
        end else if (w_set && (i_iss_rd == AW'(i))) begin
          r_bit <= 1'b1;
        end else if (i_clr_valid && (i_clr_addr == AW'(i))) begin
          r_bit <= 1'b0;
        end
      end

      assign o_busy[i] = r_bit;
    end
  endgenerate

  assign o_hazard = o_busy[i_rs1] | o_busy[i_rs2];

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_scheduler
//  Description : Schedules the single register-file write port between the
//                core datapath (source 0) and a long-latency unit (source 1).
//                Source 0 has default priority; source 1 is force-granted
//                after STARVE_LIMIT consecutive denied cycles. Writes reach
//                the register file through a one-cycle output register.
//  Ports       : clk, rst_n             - clock, async active-low reset
//                i_wr0_* / o_wr0_ready  - core writeback request
//                i_wr1_* / o_wr1_ready  - long-latency writeback request
//                i_iss_* / o_iss_ready  - issue to long-latency unit
//                i_rs1, i_rs2, o_hazard - decode operand stall
//                o_busy                 - scoreboard vector
//                o_rf_we/a3/wd          - register file write port
//                o_err                  - sticky protocol error
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int NREGS        = 32,
  parameter int WIDTH        = XLEN,
  parameter int AW           = REG_AW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr0_valid,
  input  logic [AW-1:0]    i_wr0_rd,
  input  logic [WIDTH-1:0] i_wr0_data,
  output logic             o_wr0_ready,
  input  logic             i_wr1_valid,
  input  logic [AW-1:0]    i_wr1_rd,
  input  logic [WIDTH-1:0] i_wr1_data,
  output logic             o_wr1_ready,
  input  logic             i_iss_valid,
  input  logic [AW-1:0]    i_iss_rd,
  output logic             o_iss_ready,
  input  logic [AW-1:0]    i_rs1,
  input  logic [AW-1:0]    i_rs2,
  output logic             o_hazard,
  output logic [NREGS-1:0] o_busy,
  output logic             o_rf_we,
  output logic [AW-1:0]    o_rf_a3,
  output logic [WIDTH-1:0] o_rf_wd,
  output logic             o_err
);

  localparam int             SCW        = 4;
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  logic [SCW-1:0]   r_starve;
  logic             r_we;
  logic [AW-1:0]    r_a3;
  logic [WIDTH-1:0] r_wd;
  wb_src_e          r_src;
  logic             r_err;

  logic             w_force;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_acc;
  logic [AW-1:0]    w_sel_rd;
  logic [WIDTH-1:0] w_sel_data;
  wb_src_e          w_sel_src;
  logic             w_clr_valid;
  logic             w_proto_err;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign w_force  = i_wr1_valid & (r_starve == STARVE_MAX);
  assign w_grant1 = i_wr1_valid & (w_force | ~i_wr0_valid);
  assign w_grant0 = i_wr0_valid & ~w_force;

  assign o_wr0_ready = w_grant0;
  assign o_wr1_ready = w_grant1;

  assign w_acc0 = i_wr0_valid & o_wr0_ready;
  assign w_acc1 = i_wr1_valid & o_wr1_ready;
  assign w_acc  = w_acc0 | w_acc1;

  always_comb begin
    w_sel_rd   = i_wr0_rd;
    w_sel_data = i_wr0_data;
    w_sel_src  = SRC_CORE;
    if (w_acc1) begin
      w_sel_rd   = i_wr1_rd;
      w_sel_data = i_wr1_data;
      w_sel_src  = SRC_LONG;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts consecutive denied source-1 cycles
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!i_wr1_valid || w_acc1) begin
      r_starve <= '0;
    end else if (r_starve != STARVE_MAX) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: x0 writes are accepted but never assert the write enable.
  // Address/data only update on an accept so they hold between writes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we  <= 1'b0;
      r_a3  <= '0;
      r_wd  <= '0;
      r_src <= SRC_CORE;
    end else begin
      r_we <= w_acc & (w_sel_rd != AW'(X0_IDX));
      if (w_acc) begin
        r_a3  <= w_sel_rd;
        r_wd  <= w_sel_data;
        r_src <= w_sel_src;
      end
    end
  end

  assign o_rf_we = r_we;
  assign o_rf_a3 = r_a3;
  assign o_rf_wd = r_wd;

  // ---------------------------------------------------------------------------
  // Scoreboard: busy clears when a source-1 write actually commits, so the
  // hazard covers the cycle the write spends in the output stage.
  // ---------------------------------------------------------------------------
  assign w_clr_valid = r_we & (r_src == SRC_LONG);

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_iss_valid (i_iss_valid),
    .i_iss_rd    (i_iss_rd),
    .o_iss_ready (o_iss_ready),
    .i_clr_valid (w_clr_valid),
    .i_clr_addr  (r_a3),
    .i_rs1       (i_rs1),
    .i_rs2       (i_rs2),
    .o_hazard    (o_hazard),
    .o_busy      (o_busy)
  );

  // ---------------------------------------------------------------------------
  // Protocol error: source 1 writing a register it never claimed
  // ---------------------------------------------------------------------------
  assign w_proto_err = w_acc1 & (i_wr1_rd != AW'(X0_IDX)) & ~o_busy[i_wr1_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_proto_err) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;

endmodule : regfile_wb_scheduler
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_scheduler
//  Description : Self-checking bench for regfile_wb_scheduler. Directed
//                stimulus pushes expected register-file writes into a queue;
//                a monitor pops and compares on every asserted write enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr0_valid, wr1_valid, iss_valid;
  logic [4:0]  wr0_rd, wr1_rd, iss_rd, rs1, rs2;
  logic [31:0] wr0_data, wr1_data;
  logic        wr0_ready, wr1_ready, iss_ready, hazard;
  logic [31:0] busy;
  logic        rf_we, err;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(
    .NREGS        (32),
    .WIDTH        (32),
    .AW           (5),
    .STARVE_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr0_valid (wr0_valid),
    .i_wr0_rd    (wr0_rd),
    .i_wr0_data  (wr0_data),
    .o_wr0_ready (wr0_ready),
    .i_wr1_valid (wr1_valid),
    .i_wr1_rd    (wr1_rd),
    .i_wr1_data  (wr1_data),
    .o_wr1_ready (wr1_ready),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .o_iss_ready (iss_ready),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .o_hazard    (hazard),
    .o_busy      (busy),
    .o_rf_we     (rf_we),
    .o_rf_a3     (rf_a3),
    .o_rf_wd     (rf_wd),
    .o_err       (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr0_valid = 1'b0; wr0_rd = '0; wr0_data = '0;
    wr1_valid = 1'b0; wr1_rd = '0; wr1_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    rs1 = '0; rs2 = '0;
  endtask

  task automatic expect_wr(input logic [4:0] a3, input logic [31:0] wd);
    exp_t e;
    e.a3 = a3;
    e.wd = wd;
    q.push_back(e);
  endtask

  // Monitor: every committed write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_we === 1'b1) begin
      if (q.size() == 0) begin
        chk("wb_unexpected_we", {31'd0, rf_we}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_a3", {27'd0, rf_a3}, {27'd0, e.a3});
        chk("wb_wd", rf_wd, e.wd);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    chk("rst_we",   {31'd0, rf_we}, 32'd0);
    chk("rst_a3",   {27'd0, rf_a3}, 32'd0);
    chk("rst_wd",   rf_wd, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_err",  {31'd0, err}, 32'd0);

    // Reset in the middle of an in-flight write with a busy register.
    @(negedge clk); rst_n = 1'b1;
    iss_valid = 1'b1; iss_rd = 5'd5;
    wr0_valid = 1'b1; wr0_rd = 5'd1; wr0_data = 32'h0000A5A5;
    #1;
    chk("mid_iss_ready", {31'd0, iss_ready}, 32'd1);
    chk("mid_wr0_ready", {31'd0, wr0_ready}, 32'd1);
    expect_wr(5'd1, 32'h0000A5A5);
    @(posedge clk); #1;
    idle();
    chk("mid_busy5", {31'd0, busy[5]}, 32'd1);
    chk("mid_we",    {31'd0, rf_we}, 32'd1);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_we",   {31'd0, rf_we}, 32'd0);
    chk("arst_a3",   {27'd0, rf_a3}, 32'd0);
    chk("arst_wd",   rf_wd, 32'd0);
    chk("arst_busy", busy, 32'd0);
    chk("arst_err",  {31'd0, err}, 32'd0);

    // Plain core write after reset release.
    @(negedge clk); rst_n = 1'b1;
    wr0_valid = 1'b1; wr0_rd = 5'd3; wr0_data = 32'hDEADBEEF;
    #1;
    chk("w3_ready", {31'd0, wr0_ready}, 32'd1);
    expect_wr(5'd3, 32'hDEADBEEF);

    // x0 write: accepted, but no write enable next cycle.
    @(negedge clk); idle();
    wr0_valid = 1'b1; wr0_rd = 5'd0; wr0_data = 32'h00001234;
    #1;
    chk("x0_ready", {31'd0, wr0_ready}, 32'd1);
    @(negedge clk); idle();
    #1;
    chk("x0_no_we", {31'd0, rf_we}, 32'd0);

    // Claim x20 for source 1, then both sources valid every cycle.
    iss_valid = 1'b1; iss_rd = 5'd20;
    #1;
    chk("iss20_ready", {31'd0, iss_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); idle();
      wr0_valid = 1'b1; wr0_rd = 5'(10 + i); wr0_data = 32'h100 + 32'(i);
      wr1_valid = 1'b1; wr1_rd = 5'd20;      wr1_data = 32'hCAFE0014;
      #1;
      chk("starve_rdy0", {31'd0, wr0_ready}, (i < 4) ? 32'd1 : 32'd0);
      chk("starve_rdy1", {31'd0, wr1_ready}, (i == 4) ? 32'd1 : 32'd0);
      if (i < 4) expect_wr(5'(10 + i), 32'h100 + 32'(i));
      else       expect_wr(5'd20, 32'hCAFE0014);
    end
    // Counter cleared by the forced grant: core wins again.
    @(negedge clk); idle();
    wr0_valid = 1'b1; wr0_rd = 5'd15; wr0_data = 32'h00000105;
    wr1_valid = 1'b1; wr1_rd = 5'd20; wr1_data = 32'hCAFE0014;
    #1;
    chk("post_rdy0", {31'd0, wr0_ready}, 32'd1);
    chk("post_rdy1", {31'd0, wr1_ready}, 32'd0);
    expect_wr(5'd15, 32'h00000105);
    @(negedge clk); idle();
    #1;
    chk("busy20_clr", {31'd0, busy[20]}, 32'd0);
    chk("starve_err", {31'd0, err}, 32'd0);

    // Scoreboard: issue x7, stall, then source-1 writeback.
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    chk("iss7_ready", {31'd0, iss_ready}, 32'd1);
    @(negedge clk); idle();
    rs1 = 5'd7;
    #1;
    chk("busy7_set", {31'd0, busy[7]}, 32'd1);
    chk("haz_rs1",   {31'd0, hazard}, 32'd1);
    iss_valid = 1'b1; iss_rd = 5'd7;
    rs1 = 5'd0; rs2 = 5'd7;
    #1;
    chk("iss7_waw",  {31'd0, iss_ready}, 32'd0);
    chk("haz_rs2",   {31'd0, hazard}, 32'd1);
    rs2 = 5'd0;
    #1;
    chk("haz_x0",    {31'd0, hazard}, 32'd0);
    @(negedge clk); idle();
    wr1_valid = 1'b1; wr1_rd = 5'd7; wr1_data = 32'h00000077;
    rs1 = 5'd7;
    #1;
    chk("w7_rdy1", {31'd0, wr1_ready}, 32'd1);
    chk("w7_haz",  {31'd0, hazard}, 32'd1);
    expect_wr(5'd7, 32'h00000077);
    @(negedge clk); idle();
    rs1 = 5'd7;
    #1;
    chk("w7_haz_inflight", {31'd0, hazard}, 32'd1);
    @(negedge clk); idle();
    rs1 = 5'd7;
    #1;
    chk("w7_haz_clr", {31'd0, hazard}, 32'd0);
    chk("w7_busy",    {31'd0, busy[7]}, 32'd0);
    chk("w7_err",     {31'd0, err}, 32'd0);

    // Protocol error: source-1 write to an unclaimed register.
    @(negedge clk); idle();
    wr1_valid = 1'b1; wr1_rd = 5'd9; wr1_data = 32'h00000099;
    #1;
    chk("w9_rdy1", {31'd0, wr1_ready}, 32'd1);
    expect_wr(5'd9, 32'h00000099);
    @(negedge clk); idle();
    #1;
    chk("err_set", {31'd0, err}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_wb_scheduler
`default_nettype wire
